hbridge_ctrl: RTL
=================

// Module: hbridge_ctrl
// PURPOSE
//   Dual-channel sequencer for the two-bridge motor driver. Turns per-channel
//   direction/duty commands into registered in1..in4 and enA/enB drive
//   signals: PWM on enable, brake/coast, forced dead-time on reversal.
//   Sits between the command logic and the driver stage, one per driver.
// PARAMETERS
//   PWM_W        8    duty and PWM counter width; period = 2**PWM_W clk cycles
//   DEAD_CYCLES  64   clk cycles both bridge inputs/enable held low on reversal (>=1)
// PORTS
//   clk          in   1      single clock, all logic on posedge
//   rst          in   1      asynchronous reset, active-high
//   a_cmd_valid  in   1      channel A command valid
//   a_cmd_ready  out  1      channel A can accept a command
//   a_dir        in   2      A direction: 0 COAST, 1 FWD, 2 REV, 3 BRAKE
//   a_duty       in   PWM_W  A duty, enable-high cycles per period
//   b_cmd_valid / b_cmd_ready / b_dir / b_duty  as above for channel B
//   in1, in2     out  1      bridge A inputs (registered)
//   enA          out  1      bridge A enable (registered)
//   in3, in4     out  1      bridge B inputs (registered)
//   enB          out  1      bridge B enable (registered)
//   a_busy       out  1      A in dead-time
//   b_busy       out  1      B in dead-time
// BEHAVIOUR
//   Reset: all outputs 0, PWM counter 0, both channels IDLE, duty regs 0; *_cmd_ready 1 after release.
//   Shared free-running PWM counter cnt, 0..2**PWM_W-1, wraps to 0.
//   Accept: cmd_valid && cmd_ready on posedge; dir/duty latched there.
//   cmd_ready = 1 in IDLE/RUN/BRAKE, 0 in DEAD. Channels fully independent.
//   States per channel: IDLE(coast), RUN(dir FWD|REV), BRAKE, DEAD.
//   Drive (ch A; B same on in3/in4/enB):
//     IDLE  : in1=0 in2=0 enA=0      BRAKE: in1=1 in2=1 enA=1 (no PWM)
//     RUN   : FWD in1=1 in2=0 / REV in1=0 in2=1; enA = (cnt < duty_eff)
//     DEAD  : in1=0 in2=0 enA=0; busy=1
//   Transitions on accept: COAST->IDLE; BRAKE->BRAKE; FWD/REV from IDLE/BRAKE
//     ->RUN; same dir in RUN -> stay RUN; opposite dir in RUN -> DEAD with
//     DEAD_CYCLES counter loaded, pending dir/duty stored; counter expiry -> RUN pending dir.
//   Dead-time: exactly DEAD_CYCLES cycles of all-low drive before new dir appears.
//   Latency: drive outputs change the cycle after accept (1 clk) for dir;
//     duty_eff updates only when cnt==0 (glitch-free PWM, <=1 period delay).
//   duty=0 -> en never high; duty=2**PWM_W-1 -> high all but 1 cycle/period.
//   Async rst mid-DEAD or mid-period: immediate return to reset values.
// CONFIGURATION
//   SOFT_START_EN defined: in RUN, duty_eff steps by +/-1 per PWM period
//     (at cnt==0) toward latched duty; entering RUN from IDLE/BRAKE/DEAD starts
//     duty_eff at 0.
//   SOFT_START_EN undefined: duty_eff loads latched duty at next cnt==0.
// STRUCTURE
//   Package hbridge_pkg: dir_t enum (COAST/FWD/REV/BRAKE), state_t enum
//     (IDLE/RUN/BRAKE/DEAD), default PWM_W/DEAD_CYCLES constants.
//   Sub-module hbridge_chan: one channel FSM, dead-time counter, duty_eff,
//     drive regs; top instantiates two plus the shared PWM counter.
// TESTING
//   Reset asserted mid-RUN -> all six drive outputs 0 same cycle, ready=1 after release.
//   A FWD duty=64 -> in1=1 in2=0, enA high exactly 64 of each 256 cycles.
//   A FWD then REV -> enA/in1/in2=0 for 64 cycles, busy=1, ready=0; then in2=1 PWM.
//   B BRAKE -> in3=in4=enB=1 steady; then COAST -> all 0 next cycle.
//   A duty 200->20 mid-period -> new duty only from next cnt==0; B unaffected.
//   SOFT_START_EN: FWD duty=4 from IDLE -> enA high 0,1,2,3,4,4.. cycles per period.

Source files
------------

// File: rtl/hbridge_pkg.sv
// -----------------------------------------------------------------------------
// hbridge_pkg
//   Shared types and defaults for the dual-channel H-bridge sequencer.
//   dir_t   : command direction encoding as seen on the *_dir ports.
//   state_t : per-channel sequencer state.
//   is_reversal() : true when a new running direction opposes the current one.
//   Optional feature macro used by the importing files: SOFT_START_EN.
// -----------------------------------------------------------------------------
package hbridge_pkg;

  localparam int DEF_PWM_W       = 8;
  localparam int DEF_DEAD_CYCLES = 64;

  typedef enum logic [1:0] {
    DIR_COAST = 2'd0,
    DIR_FWD   = 2'd1,
    DIR_REV   = 2'd2,
    DIR_BRAKE = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BRAKE,
    ST_DEAD
  } state_t;

  function automatic logic is_reversal(input dir_t cur, input dir_t nxt);
    return ((cur == DIR_FWD) && (nxt == DIR_REV)) ||
           ((cur == DIR_REV) && (nxt == DIR_FWD));
  endfunction

endpackage

// File: rtl/hbridge_chan.sv
// -----------------------------------------------------------------------------
// hbridge_chan
//   One bridge channel: command handshake, IDLE/RUN/BRAKE/DEAD sequencer,
//   dead-time counter, effective duty register and registered drive outputs.
//   Optional feature: SOFT_START_EN (duty_eff ramps +/-1 per PWM period).
//
//   Ports
//     clk, rst     clock, asynchronous active-high reset
//     cnt_nxt      value the shared PWM counter takes at the next posedge
//     cmd_valid    command valid
//     cmd_ready    command can be accepted (low only during dead-time)
//     cmd_dir      commanded direction
//     cmd_duty     commanded duty (enable-high cycles per period)
//     drv_p/drv_n  bridge inputs (in1/in2 or in3/in4), registered
//     drv_en       bridge enable, registered
//     busy         channel is in dead-time, registered
//
//   All outputs are registered from the *next* state so that, in any cycle,
//   they describe the state and PWM count visible in that same cycle.
// -----------------------------------------------------------------------------
module hbridge_chan
  import hbridge_pkg::*;
#(
  parameter int PWM_W       = DEF_PWM_W,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] cnt_nxt,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  dir_t             cmd_dir,
  input  logic [PWM_W-1:0] cmd_duty,
  output logic             drv_p,
  output logic             drv_n,
  output logic             drv_en,
  output logic             busy
);

  // Counter holds DEAD_CYCLES-1 down to 0, so the DEAD state lasts exactly
  // DEAD_CYCLES cycles.
  localparam int             DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [DW-1:0]  DEAD_ONE  = DW'(1);

  state_t           state_q, state_nxt;
  dir_t             dir_q, dir_nxt;
  logic [PWM_W-1:0] duty_q, duty_nxt;
  logic [PWM_W-1:0] eff_q, eff_nxt;
  logic [DW-1:0]    dead_q, dead_nxt;

  logic accept;
  logic wrap;
  logic p_nxt, n_nxt, en_nxt, busy_nxt, ready_nxt;

  assign accept = cmd_valid & cmd_ready;
  assign wrap   = (cnt_nxt == '0);

  // Sequencer next state. dir_q doubles as the pending direction while in
  // DEAD; no command is accepted there, so it is stable until expiry.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state_q;
    dir_nxt   = dir_q;
    duty_nxt  = duty_q;
    dead_nxt  = dead_q;

    if (accept) begin
      dir_nxt  = cmd_dir;
      duty_nxt = cmd_duty;
    end

    case (state_q)
      ST_DEAD: begin
        if (dead_q == '0) state_nxt = ST_RUN;
        else              dead_nxt  = dead_q - DEAD_ONE;
      end
      default: begin
        if (accept) begin
          case (cmd_dir)
            DIR_COAST: state_nxt = ST_IDLE;
            DIR_BRAKE: state_nxt = ST_BRAKE;
            default: begin
              if ((state_q == ST_RUN) && is_reversal(dir_q, cmd_dir)) begin
                state_nxt = ST_DEAD;
                dead_nxt  = DEAD_LOAD;
              end else begin
                state_nxt = ST_RUN;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Effective duty only moves at the period boundary so a pulse is never cut
  // short or stretched mid-period.
`ifdef SOFT_START_EN
  localparam logic [PWM_W-1:0] DUTY_ONE = PWM_W'(1);

  always_comb begin
    eff_nxt = eff_q;
    if ((state_nxt != ST_RUN) || (state_q != ST_RUN)) begin
      // Held at 0 outside RUN and on the entry edge so every start ramps up.
      eff_nxt = '0;
    end else if (wrap) begin
      if (eff_q < duty_nxt)      eff_nxt = eff_q + DUTY_ONE;
      else if (eff_q > duty_nxt) eff_nxt = eff_q - DUTY_ONE;
    end
  end
`else
  always_comb begin
    eff_nxt = eff_q;
    if (wrap) eff_nxt = duty_nxt;
  end
`endif

  // Drive decode for the state visible after this edge.
  always_comb begin
    p_nxt     = 1'b0;
    n_nxt     = 1'b0;
    en_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    ready_nxt = (state_nxt != ST_DEAD);
    case (state_nxt)
      ST_RUN: begin
        p_nxt  = (dir_nxt == DIR_FWD);
        n_nxt  = (dir_nxt == DIR_REV);
        en_nxt = (cnt_nxt < eff_nxt);
      end
      ST_BRAKE: begin
        p_nxt  = 1'b1;
        n_nxt  = 1'b1;
        en_nxt = 1'b1;
      end
      ST_DEAD:  busy_nxt = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: every register here is reset, including duty/eff data registers,
  // because a reset mid-period must return the drive to a known-safe state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_COAST;
      duty_q    <= '0;
      eff_q     <= '0;
      dead_q    <= '0;
      drv_p     <= 1'b0;
      drv_n     <= 1'b0;
      drv_en    <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      dir_q     <= dir_nxt;
      duty_q    <= duty_nxt;
      eff_q     <= eff_nxt;
      dead_q    <= dead_nxt;
      drv_p     <= p_nxt;
      drv_n     <= n_nxt;
      drv_en    <= en_nxt;
      busy      <= busy_nxt;
      cmd_ready <= ready_nxt;
    end
  end

endmodule

// File: rtl/hbridge_ctrl.sv
// -----------------------------------------------------------------------------
// hbridge_ctrl
//   Dual-channel sequencer for the two-bridge motor driver. Owns the shared
//   free-running PWM counter and instantiates one hbridge_chan per bridge.
//   Optional feature: SOFT_START_EN (see hbridge_chan).
//
//   Ports
//     clk, rst                          clock, asynchronous active-high reset
//     a_cmd_valid/a_cmd_ready           channel A command handshake
//     a_dir, a_duty                     channel A command (0 COAST,1 FWD,2 REV,3 BRAKE)
//     b_cmd_valid/b_cmd_ready/b_dir/b_duty   same for channel B
//     in1, in2, enA                     bridge A drive (registered)
//     in3, in4, enB                     bridge B drive (registered)
//     a_busy, b_busy                    channel in dead-time
// -----------------------------------------------------------------------------
module hbridge_ctrl
  import hbridge_pkg::*;
#(
  parameter int PWM_W       = DEF_PWM_W,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_cmd_valid,
  output logic             a_cmd_ready,
  input  logic [1:0]       a_dir,
  input  logic [PWM_W-1:0] a_duty,
  input  logic             b_cmd_valid,
  output logic             b_cmd_ready,
  input  logic [1:0]       b_dir,
  input  logic [PWM_W-1:0] b_duty,
  output logic             in1,
  output logic             in2,
  output logic             enA,
  output logic             in3,
  output logic             in4,
  output logic             enB,
  output logic             a_busy,
  output logic             b_busy
);

  localparam logic [PWM_W-1:0] CNT_ONE = PWM_W'(1);

  logic [PWM_W-1:0] cnt_q, cnt_nxt;

  // Period is 2**PWM_W; the wrap to 0 comes from natural overflow.
  assign cnt_nxt = cnt_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_nxt;
  end

  hbridge_chan #(
    .PWM_W       (PWM_W),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .cnt_nxt   (cnt_nxt),
    .cmd_valid (a_cmd_valid),
    .cmd_ready (a_cmd_ready),
    .cmd_dir   (dir_t'(a_dir)),
    .cmd_duty  (a_duty),
    .drv_p     (in1),
    .drv_n     (in2),
    .drv_en    (enA),
    .busy      (a_busy)
  );

  hbridge_chan #(
    .PWM_W       (PWM_W),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .cnt_nxt   (cnt_nxt),
    .cmd_valid (b_cmd_valid),
    .cmd_ready (b_cmd_ready),
    .cmd_dir   (dir_t'(b_dir)),
    .cmd_duty  (b_duty),
    .drv_p     (in3),
    .drv_n     (in4),
    .drv_en    (enB),
    .busy      (b_busy)
  );

endmodule
